module_keypad_scan: RTL and testbench
=====================================

# module_keypad_scan

Scans a 4×4 matrix keypad and delivers debounced 4-bit key codes to the display path. Columns are driven active-low one at a time and rows are read through pull-ups. A key is reported only after it is seen identically on several consecutive full scans. The output feeds the binary-code input of the binary-to-BCD / 7-segment chain, so a pressed key appears on the display.

## Interface
Parameters:
- `INPUT_REFRESH`, default 2700000: clock cycles per column dwell (scan tick period); must be ≥ 4.
- `DEBOUNCE_SCANS`, default 3: consecutive identical full scans required to accept a press, and consecutive empty scans required to accept a release; range 1..15.

Ports:
- `clk_i`  input  1  system clock; the only clock.
- `rst_i`  input  1  reset, asynchronous and active-low.
- `row_i`  input  4  keypad rows, asynchronous, active-low (pull-ups external).
- `col_o`  output 4  keypad column drive, one-hot active-low.
- `key_o`  output 4  last accepted key code = {row index[1:0], column index[1:0]}.
- `key_valid_o`  output 1  one-cycle pulse when a new press is accepted.
- `key_held_o`  output 1  high while the accepted key is considered held.

## Operation
- Reset values: `col_o`=4'b1110, `key_o`=0, `key_valid_o`=0, `key_held_o`=0, FSM in IDLE, all counters 0.
- `row_i` passes through a 2-flop synchronizer before any use.
- Tick: a counter of width $clog2(INPUT_REFRESH) asserts a one-cycle tick every INPUT_REFRESH cycles.
- On each tick:
  - Sample the synchronized rows for the currently driven column.
  - Then rotate `col_o` left (1110→1101→1011→0111→1110).
- Full scan: 4 ticks, covering columns 0..3. At scan end, the scan result is (found, code).
  - found = any low row in any column.
  - code = the first hit in order column 0..3, then row 0..3 (lowest column wins, then lowest row).
- FSM, evaluated once per scan end:
  - IDLE: if found → DEBOUNCE, cand←code, cnt←1; if DEBOUNCE_SCANS=1, go directly to accept.
  - DEBOUNCE:
    - found && code==cand → cnt+1.
    - When cnt reaches DEBOUNCE_SCANS → accept: `key_o`←cand, pulse `key_valid_o`, `key_held_o`←1, go to PRESSED.
    - Any other result → IDLE, cnt←0.
  - PRESSED:
    - found (any key, including a different one) → rel_cnt←0.
    - Not found → rel_cnt+1; at DEBOUNCE_SCANS → IDLE, `key_held_o`←0.
- `key_o` holds its value after release until the next accepted press.
- Simultaneous keys: the priority rule above applies; no rollover reporting.
- Asynchronous reset asserted mid-scan or mid-debounce returns every register to its reset value immediately.

## Timing
- Rows for a column are sampled at the tick ending that column's dwell, giving INPUT_REFRESH−2 settle cycles after synchronization.
- `key_valid_o` and `key_held_o` rise in the cycle after the scan-end tick that completes the DEBOUNCE_SCANS-th matching scan.
- `key_valid_o` is exactly 1 cycle wide and never re-fires while in PRESSED.
- Press-to-pulse latency, for a key stable from before a scan start: DEBOUNCE_SCANS×4×INPUT_REFRESH + 1 cycles. Worst case adds one extra scan.
- Release-to-`key_held_o`-low latency: DEBOUNCE_SCANS scans after the first fully empty scan.
- Tick counter wraps from INPUT_REFRESH−1 to 0; the column index wraps from 3 to 0.

## Structure
- Shared package `keypad_pkg`:
  - `KEY_W`=4, `N_COLS`=4, `N_ROWS`=4.
  - FSM state typedef {IDLE, DEBOUNCE, PRESSED}.
  - Column reset pattern 4'b1110.
- One sub-module, `module_scan_tick`: parameterized INPUT_REFRESH; outputs the tick pulse and the 2-bit column index. Same reset as the parent.
- Synchronizer, scan accumulation and FSM live in the top of the block.

## Test plan
Bench parameters: INPUT_REFRESH=8, DEBOUNCE_SCANS=3.
- Reset then idle, rows=4'hF → `col_o` cycles 1110,1101,1011,0111 with a new value every 8 cycles; `key_valid_o` never pulses.
- Hold row 2 low whenever column 1 is driven (steady press) → one `key_valid_o` pulse, `key_o`=4'h9, `key_held_o`=1 within 3–4 scans (≤ 129 cycles from a scan start).
- Bouncing press: key 4'h9 present only on alternating scans for 10 scans → no pulse; `key_held_o` stays 0.
- Release after acceptance, rows=4'hF → `key_held_o` falls 3 scans later; `key_o` stays 4'h9. Re-pressing 4'h5 then yields a new pulse with `key_o`=4'h5.
- Keys (row1,col3) and (row0,col2) pressed together → `key_o`=4'h2 (lower column wins).
- Drive `rst_i` low during DEBOUNCE with cnt=2 → outputs return to reset values at once. After `rst_i` rises, a full 3 new scans are required before any pulse.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state type and column-drive helper for the keypad scanner.
package keypad_pkg;

    localparam int KEY_W  = 4;
    localparam int N_COLS = 4;
    localparam int N_ROWS = 4;

    // Column 0 driven low, the others released.
    localparam logic [N_COLS-1:0] COL_RESET = 4'b1110;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2
    } state_t;

    // One-hot active-low drive pattern for a column index.
    function automatic logic [N_COLS-1:0] col_drive(input logic [1:0] idx);
        return ~(COL_RESET ^ {N_COLS{1'b1}}) << idx | ~(4'b1111 << idx);
    endfunction

endpackage

// File: rtl/module_keypad_scan_tick.sv
// Column dwell timer: a one-cycle tick every INPUT_REFRESH cycles and the
// index of the column currently being driven.
module module_scan_tick #(
    parameter int INPUT_REFRESH = 2700000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic       tick_o,
    output logic [1:0] col_idx_o
);

    localparam int CNT_W = (INPUT_REFRESH > 1) ? $clog2(INPUT_REFRESH) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(INPUT_REFRESH - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       col_q, col_d;

    // Tick on the last cycle of each dwell, then wrap the counter and advance the column.
    always_comb begin
        tick_o = (cnt_q == CNT_MAX);
        cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);
        col_d  = tick_o ? col_q + 2'd1 : col_q;
    end

    // Dwell counter and column index registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            col_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            col_q <= col_d;
        end
    end

    assign col_idx_o = col_q;

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 matrix keypad scanner: drives columns one at a time, collects one full
// scan of row hits, and debounces presses/releases over whole scans.
module module_keypad_scan
    import keypad_pkg::*;
#(
    parameter int INPUT_REFRESH  = 2700000,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [N_ROWS-1:0] row_i,
    output logic [N_COLS-1:0] col_o,
    output logic [KEY_W-1:0]  key_o,
    output logic              key_valid_o,
    output logic              key_held_o
);

    localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

    logic             tick;
    logic [1:0]       col_idx;

    logic [N_ROWS-1:0] row_meta_q, row_meta_d, row_sync_q, row_sync_d;
    logic              acc_found_q, acc_found_d;
    logic [KEY_W-1:0]  acc_code_q, acc_code_d;
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d, rel_cnt_q, rel_cnt_d;
    logic [KEY_W-1:0]  cand_q, cand_d, key_q, key_d;
    logic              valid_q, valid_d, held_q, held_d;

    logic              row_hit;
    logic [1:0]        row_idx;
    logic              scan_end, scan_found;
    logic [KEY_W-1:0]  scan_code;

    module_scan_tick #(.INPUT_REFRESH(INPUT_REFRESH)) u_tick (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tick_o    (tick),
        .col_idx_o (col_idx)
    );

    // Lowest-numbered low row in the currently driven column.
    always_comb begin
        row_hit = 1'b0;
        row_idx = 2'd0;
        for (int r = N_ROWS - 1; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                row_hit = 1'b1;
                row_idx = 2'(r);
            end
        end
    end

    // Merge this column into the running scan; column 0 starts a fresh scan,
    // and an earlier column's hit always keeps priority.
    always_comb begin
        row_meta_d  = row_i;
        row_sync_d  = row_meta_q;
        scan_end    = tick && (col_idx == 2'd3);
        scan_found  = (col_idx != 2'd0) && acc_found_q;
        scan_code   = (col_idx != 2'd0) ? acc_code_q : '0;
        if (!scan_found && row_hit) begin
            scan_code = {row_idx, col_idx};
        end
        scan_found  = scan_found || row_hit;
        acc_found_d = tick ? scan_found : acc_found_q;
        acc_code_d  = tick ? scan_code  : acc_code_q;
    end

    // Debounce FSM, evaluated once per completed scan.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rel_cnt_d = rel_cnt_q;
        cand_d    = cand_q;
        key_d     = key_q;
        held_d    = held_q;
        valid_d   = 1'b0;
        if (scan_end) begin
            unique case (state_q)
                IDLE: begin
                    if (scan_found) begin
                        cand_d = scan_code;
                        if (DEB_N == 4'd1) begin
                            key_d     = scan_code;
                            valid_d   = 1'b1;
                            held_d    = 1'b1;
                            cnt_d     = 4'd0;
                            rel_cnt_d = 4'd0;
                            state_d   = PRESSED;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (scan_found && scan_code == cand_q) begin
                        if (cnt_q + 4'd1 == DEB_N) begin
                            key_d     = cand_q;
                            valid_d   = 1'b1;
                            held_d    = 1'b1;
                            cnt_d     = 4'd0;
                            rel_cnt_d = 4'd0;
                            state_d   = PRESSED;
                        end else begin
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = IDLE;
                    end
                end
                PRESSED: begin
                    if (scan_found) begin
                        rel_cnt_d = 4'd0;
                    end else if (rel_cnt_q + 4'd1 == DEB_N) begin
                        rel_cnt_d = 4'd0;
                        held_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        rel_cnt_d = rel_cnt_q + 4'd1;
                    end
                end
                default: begin
                    cnt_d     = 4'd0;
                    rel_cnt_d = 4'd0;
                    held_d    = 1'b0;
                    state_d   = IDLE;
                end
            endcase
        end
    end

    // All state registers; reset returns everything to idle at once.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            row_meta_q  <= '1;
            row_sync_q  <= '1;
            acc_found_q <= 1'b0;
            acc_code_q  <= '0;
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            rel_cnt_q   <= 4'd0;
            cand_q      <= '0;
            key_q       <= '0;
            valid_q     <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            row_meta_q  <= row_meta_d;
            row_sync_q  <= row_sync_d;
            acc_found_q <= acc_found_d;
            acc_code_q  <= acc_code_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rel_cnt_q   <= rel_cnt_d;
            cand_q      <= cand_d;
            key_q       <= key_d;
            valid_q     <= valid_d;
            held_q      <= held_d;
        end
    end

    assign col_o       = col_drive(col_idx);
    assign key_o       = key_q;
    assign key_valid_o = valid_q;
    assign key_held_o  = held_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Self-checking bench for module_keypad_scan: a behavioural keypad matrix
// feeds the rows, expected key codes are queued at press time and compared
// whenever the scanner pulses key_valid_o.
module tb_module_keypad_scan;

    localparam int REFRESH  = 8;
    localparam int SCANS    = 3;
    localparam int SCAN_CYC = 4 * REFRESH;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row_i, col_o, key_o;
    logic        key_valid_o, key_held_o;
    logic [15:0] keys;                 // bit row*4+col set = key pressed

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          pulses       = 0;
    logic [3:0]  exp_q[$];

    always #5 clk = ~clk;

    module_keypad_scan #(.INPUT_REFRESH(REFRESH), .DEBOUNCE_SCANS(SCANS)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .row_i       (row_i),
        .col_o       (col_o),
        .key_o       (key_o),
        .key_valid_o (key_valid_o),
        .key_held_o  (key_held_o)
    );

    // Passive switch matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row_i = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Scoreboard: every key_valid_o pulse must match the oldest queued press.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && key_valid_o === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) check_val("unexpected_pulse", {31'd0, key_valid_o}, 32'd0);
            else                   check_val("key_code", {28'd0, key_o}, {28'd0, exp_q.pop_front()});
        end
    end

    // Return at the negedge just after the scan-end tick (column back to 0).
    task automatic wait_scan_start();
        logic [3:0] prev;
        bit         seen = 0;
        prev = col_o;
        for (int i = 0; i < 2 * SCAN_CYC && !seen; i++) begin
            @(negedge clk);
            if (col_o == 4'b1110 && prev == 4'b0111) seen = 1;
            prev = col_o;
        end
        if (!seen) check_val("scan_start_timeout", {31'd0, seen}, 32'd1);
    endtask

    // Count negedges until key_valid_o is seen.
    task automatic wait_pulse(output int lat);
        bit got = 0;
        lat = 0;
        for (int i = 1; i <= 4 * SCAN_CYC + 8 && !got; i++) begin
            @(negedge clk);
            if (key_valid_o) begin
                got = 1;
                lat = i;
            end
        end
        if (!got) check_val("pulse_timeout", {31'd0, got}, 32'd1);
    endtask

    task automatic wait_held_low();
        bit low = 0;
        for (int i = 0; i < 5 * SCAN_CYC && !low; i++) begin
            @(negedge clk);
            if (!key_held_o) low = 1;
        end
        if (!low) check_val("held_low_timeout", {31'd0, low}, 32'd1);
    endtask

    initial begin
        logic [3:0] col_exp [5];
        int lat, p0;
        col_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n = 1'b0;
        keys  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check_val("rst_col",   {28'd0, col_o}, 32'h0E);
        check_val("rst_key",   {28'd0, key_o}, 32'h0);
        check_val("rst_valid", {31'd0, key_valid_o}, 32'd0);
        check_val("rst_held",  {31'd0, key_held_o}, 32'd0);
        rst_n = 1'b1;

        // Idle column rotation: new column every REFRESH cycles, wrap 3 -> 0
        for (int k = 0; k < 5; k++) begin
            repeat (k == 0 ? REFRESH / 2 : REFRESH) @(negedge clk);
            check_val($sformatf("col_rot%0d", k), {28'd0, col_o}, {28'd0, col_exp[k]});
        end

        // Steady press of row2/col1 -> code 9 after exactly 3 scans
        wait_scan_start();
        exp_q.push_back(4'h9);
        keys = 16'h0200;
        wait_pulse(lat);
        // negedge count from scan start: pulse visible right after the 3rd scan-end tick
        check_val("press_latency", lat, SCANS * SCAN_CYC);
        check_val("press_held", {31'd0, key_held_o}, 32'd1);
        repeat (2 * SCAN_CYC) @(negedge clk);
        check_val("held_stays", {31'd0, key_held_o}, 32'd1);

        // Release: held drops after 3 empty scans, key_o keeps last code
        wait_scan_start();
        keys = '0;
        repeat (SCANS * SCAN_CYC - 1) @(negedge clk);
        check_val("rel_held_before", {31'd0, key_held_o}, 32'd1);
        @(negedge clk);
        check_val("rel_held_after", {31'd0, key_held_o}, 32'd0);
        check_val("rel_key_kept", {28'd0, key_o}, 32'h9);

        // Re-press row1/col1 -> code 5
        wait_scan_start();
        exp_q.push_back(4'h5);
        keys = 16'h0020;
        wait_pulse(lat);
        check_val("repress_held", {31'd0, key_held_o}, 32'd1);
        keys = '0;
        wait_held_low();

        // Bouncing key: present only on alternate scans, never accepted
        p0 = pulses;
        for (int s = 0; s < 10; s++) begin
            wait_scan_start();
            keys = (s % 2 == 0) ? 16'h0200 : 16'h0000;
        end
        wait_scan_start();
        keys = '0;
        check_val("bounce_pulses", pulses - p0, 32'd0);
        check_val("bounce_held", {31'd0, key_held_o}, 32'd0);

        // Two keys at once: (row1,col3) and (row0,col2) -> lower column wins, code 2
        wait_scan_start();
        exp_q.push_back(4'h2);
        keys = 16'h0084;
        wait_pulse(lat);
        check_val("multi_key", {28'd0, key_o}, 32'h2);
        keys = '0;
        wait_held_low();

        // Reset in the middle of debounce (two matching scans done)
        wait_scan_start();
        keys = 16'h0200;
        repeat (2 * SCAN_CYC + 10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_col",   {28'd0, col_o}, 32'h0E);
        check_val("mid_rst_key",   {28'd0, key_o}, 32'h0);
        check_val("mid_rst_valid", {31'd0, key_valid_o}, 32'd0);
        check_val("mid_rst_held",  {31'd0, key_held_o}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(4'h9);
        wait_pulse(lat);
        check_val("post_rst_latency", lat, SCANS * SCAN_CYC);
        keys = '0;
        wait_held_low();

        check_val("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
